// File: rtl/icache_refill_collector.sv
// Icache downstream refill collector: gathers out-of-order rxdat beats into
// per-MSHR line buffers and hands completed lines out round-robin on one fill port.
module icache_refill_collector #(
    parameter int ENTRY_NUM   = 8,
    parameter int ENTRY_IDX_W = 3,
    parameter int BEAT_W      = 128,
    parameter int BEATS       = 4,
    parameter int BEAT_IDX_W  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      alloc_vld,
    input  logic [ENTRY_IDX_W-1:0]    alloc_entry_id,
    input  logic                      rxdat_vld,
    output logic                      rxdat_rdy,
    input  logic [ENTRY_IDX_W-1:0]    rxdat_entry_id,
    input  logic [BEAT_IDX_W-1:0]     rxdat_beat_id,
    input  logic [BEAT_W-1:0]         rxdat_data,
    input  logic                      rxdat_err,
    output logic                      fill_vld,
    input  logic                      fill_rdy,
    output logic [ENTRY_IDX_W-1:0]    fill_entry_id,
    output logic [BEAT_W*BEATS-1:0]   fill_data,
    output logic                      fill_err,
    output logic [ENTRY_IDX_W:0]      pending_cnt,
    output logic                      proto_err
);
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

    logic                   r_rdy;
    logic                   r_fill_vld;
    logic [ENTRY_IDX_W-1:0] r_fill_id;
    logic                   r_fill_err;
    logic [ENTRY_IDX_W-1:0] r_ptr;
    logic [ENTRY_IDX_W:0]   r_pending;
    logic                   r_proto;

    logic                   w_hs;
    logic                   w_beat_acc;
    logic [BEATS-1:0]       w_beat_oh;
    logic [ENTRY_IDX_W-1:0] w_ptr;
    logic [ENTRY_NUM-1:0]   w_done;
    logic [ENTRY_NUM-1:0]   w_retire;
    logic [ENTRY_NUM-1:0]   w_busy_nxt;
    logic [ENTRY_NUM-1:0]   w_viol;
    logic [ENTRY_NUM-1:0]   w_errf;
    logic [ENTRY_NUM-1:0][BEAT_W*BEATS-1:0] w_lines;
    logic                   w_sel_vld;
    logic [ENTRY_IDX_W-1:0] w_sel_id;
    logic [ENTRY_IDX_W-1:0] w_idx;
    logic [ENTRY_IDX_W:0]   w_pend_nxt;

    assign w_beat_acc = rxdat_vld && r_rdy;
    assign w_beat_oh  = BEATS'(1) << rxdat_beat_id;
    assign w_hs       = r_fill_vld && fill_rdy;
    // Pointer moves past the granted entry in the same cycle so the next pick already sees it
    assign w_ptr      = w_hs ? ENTRY_IDX_W'(r_fill_id + 1'b1) : r_ptr;

    for (genvar e = 0; e < ENTRY_NUM; e++) begin : g_ent
        state_t                      r_state;
        logic [BEATS-1:0]            r_mask;
        logic                        r_errf;
        logic [BEATS-1:0][BEAT_W-1:0] r_buf;
        state_t                      w_state_nxt;
        logic                        w_alloc_hit, w_alloc_ok, w_beat_hit, w_coll, w_cap;
        logic [BEATS-1:0]            w_mask_nxt;
        logic                        w_errf_nxt;

        assign w_alloc_hit = alloc_vld && (alloc_entry_id == ENTRY_IDX_W'(e));
        assign w_retire[e] = w_hs && (r_fill_id == ENTRY_IDX_W'(e));
        assign w_alloc_ok  = w_alloc_hit && (r_state == S_IDLE || w_retire[e]);
        assign w_beat_hit  = w_beat_acc && (rxdat_entry_id == ENTRY_IDX_W'(e));
        // A same-cycle legal alloc opens the entry before the beat lands
        assign w_coll      = w_alloc_ok || (r_state == S_COLLECT);
        assign w_cap       = w_beat_hit && w_coll;
        assign w_mask_nxt  = (w_alloc_ok ? '0 : r_mask) | (w_cap ? w_beat_oh : '0);
        assign w_errf_nxt  = (!w_alloc_ok && r_errf) || (w_cap && rxdat_err);
        assign w_viol[e]   = (w_alloc_hit && !w_alloc_ok) || (w_beat_hit && !w_coll) ||
                             (w_cap && !w_alloc_ok && r_mask[rxdat_beat_id]);
        assign w_done[e]     = (r_state == S_DONE);
        assign w_errf[e]     = r_errf;
        assign w_lines[e]    = r_buf;
        assign w_busy_nxt[e] = (w_state_nxt != S_IDLE);

        always_comb begin
            w_state_nxt = r_state;
            if (w_alloc_ok)
                w_state_nxt = S_COLLECT;
            else if (r_state == S_COLLECT && (&w_mask_nxt))
                w_state_nxt = S_DONE;
            else if (w_retire[e])
                w_state_nxt = S_IDLE;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= S_IDLE;
                r_mask  <= '0;
                r_errf  <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_mask  <= w_mask_nxt;
                r_errf  <= w_errf_nxt;
            end
        end

        always_ff @(posedge clk) begin
            if (w_cap) r_buf[rxdat_beat_id] <= rxdat_data;
        end
    end

    always_comb begin
        w_sel_vld = 1'b0;
        w_sel_id  = '0;
        w_idx     = '0;
        for (int k = 0; k < ENTRY_NUM; k++) begin
            w_idx = w_ptr + ENTRY_IDX_W'(k);
            if (!w_sel_vld && w_done[w_idx] && !w_retire[w_idx]) begin
                w_sel_vld = 1'b1;
                w_sel_id  = w_idx;
            end
        end
    end

    always_comb begin
        w_pend_nxt = '0;
        for (int k = 0; k < ENTRY_NUM; k++)
            w_pend_nxt = w_pend_nxt + (ENTRY_IDX_W+1)'(w_busy_nxt[k]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy      <= 1'b0;
            r_fill_vld <= 1'b0;
            r_fill_id  <= '0;
            r_fill_err <= 1'b0;
            r_ptr      <= '0;
            r_pending  <= '0;
            r_proto    <= 1'b0;
        end else begin
            r_rdy     <= 1'b1;
            r_ptr     <= w_ptr;
            r_pending <= w_pend_nxt;
            r_proto   <= r_proto | (|w_viol);
            if (!r_fill_vld || fill_rdy) begin
                r_fill_vld <= w_sel_vld;
                if (w_sel_vld) begin
                    r_fill_id  <= w_sel_id;
                    r_fill_err <= w_errf[w_sel_id];
                end
            end
        end
    end

    assign rxdat_rdy     = r_rdy;
    assign fill_vld      = r_fill_vld;
    assign fill_entry_id = r_fill_id;
    assign fill_err      = r_fill_err;
    assign fill_data     = w_lines[r_fill_id];
    assign pending_cnt   = r_pending;
    assign proto_err     = r_proto;
endmodule

// File: tb/tb_icache_refill_collector.sv
// Directed vector bench for icache_refill_collector: per-cycle stimulus rows with
// hand-computed fill/pending/proto expectations, plus a mid-collect reset sequence.
module tb_icache_refill_collector;
    localparam int EW = 3;
    localparam int BW = 128;
    localparam int NB = 4;

    logic            clk, rst_n;
    logic            alloc_vld;
    logic [EW-1:0]   alloc_entry_id;
    logic            rxdat_vld, rxdat_rdy;
    logic [EW-1:0]   rxdat_entry_id;
    logic [1:0]      rxdat_beat_id;
    logic [BW-1:0]   rxdat_data;
    logic            rxdat_err;
    logic            fill_vld, fill_rdy;
    logic [EW-1:0]   fill_entry_id;
    logic [BW*NB-1:0] fill_data;
    logic            fill_err;
    logic [EW:0]     pending_cnt;
    logic            proto_err;

    icache_refill_collector dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_vld(alloc_vld), .alloc_entry_id(alloc_entry_id),
        .rxdat_vld(rxdat_vld), .rxdat_rdy(rxdat_rdy),
        .rxdat_entry_id(rxdat_entry_id), .rxdat_beat_id(rxdat_beat_id),
        .rxdat_data(rxdat_data), .rxdat_err(rxdat_err),
        .fill_vld(fill_vld), .fill_rdy(fill_rdy),
        .fill_entry_id(fill_entry_id), .fill_data(fill_data), .fill_err(fill_err),
        .pending_cnt(pending_cnt), .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic av; logic [EW-1:0] aid;
        logic bv; logic [EW-1:0] bid; logic [1:0] bt; logic [7:0] dat; logic berr;
        logic rdy;
        logic evld; logic [EW-1:0] eid; logic eerr; logic [31:0] edat;
        logic [EW:0] epend; logic eproto;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   sec6;

    task automatic add(input int av, input int aid, input int bv, input int bid, input int bt,
                       input int dat, input int berr, input int rdy, input int evld, input int eid,
                       input int eerr, input logic [31:0] edat, input int epend, input int eproto);
        vec_t r;
        r.av = av[0];  r.aid = aid[EW-1:0]; r.bv = bv[0]; r.bid = bid[EW-1:0];
        r.bt = bt[1:0]; r.dat = dat[7:0];   r.berr = berr[0]; r.rdy = rdy[0];
        r.evld = evld[0]; r.eid = eid[EW-1:0]; r.eerr = eerr[0]; r.edat = edat;
        r.epend = epend[EW:0]; r.eproto = eproto[0];
        tbl.push_back(r);
    endtask

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [EW-1:0] aid, input logic bv,
                         input logic [EW-1:0] bid, input logic [1:0] bt, input logic [7:0] dat,
                         input logic berr, input logic rdy);
        alloc_vld = av; alloc_entry_id = aid;
        rxdat_vld = bv; rxdat_entry_id = bid; rxdat_beat_id = bt;
        rxdat_data = {16{dat}}; rxdat_err = berr; fill_rdy = rdy;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " rxdat_rdy"},     BW'(rxdat_rdy), '0);
        chk({tag, " fill_vld"},      BW'(fill_vld), '0);
        chk({tag, " fill_entry_id"}, BW'(fill_entry_id), '0);
        chk({tag, " fill_err"},      BW'(fill_err), '0);
        chk({tag, " pending_cnt"},   BW'(pending_cnt), '0);
        chk({tag, " proto_err"},     BW'(proto_err), '0);
    endtask

    task automatic run_rows(input int lo, input int hi);
        vec_t r;
        logic [7:0] b;
        for (int i = lo; i < hi; i++) begin
            r = tbl[i];
            drive(r.av, r.aid, r.bv, r.bid, r.bt, r.dat, r.berr, r.rdy);
            @(posedge clk); #1;
            chk($sformatf("row%0d rxdat_rdy", i), BW'(rxdat_rdy), BW'(1));
            chk($sformatf("row%0d fill_vld", i), BW'(fill_vld), BW'(r.evld));
            if (r.evld) begin
                chk($sformatf("row%0d fill_entry_id", i), BW'(fill_entry_id), BW'(r.eid));
                chk($sformatf("row%0d fill_err", i), BW'(fill_err), BW'(r.eerr));
                for (int k = 0; k < NB; k++) begin
                    b = r.edat[k*8 +: 8];
                    chk($sformatf("row%0d fill_data beat%0d", i, k), fill_data[k*BW +: BW], {16{b}});
                end
            end
            chk($sformatf("row%0d pending_cnt", i), BW'(pending_cnt), BW'(r.epend));
            chk($sformatf("row%0d proto_err", i), BW'(proto_err), BW'(r.eproto));
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // in-order refill, entry 3
        add(1,3, 0,0,0,0,0, 1,  0,0,0,0, 1,0);
        for (int k = 0; k < 4; k++) add(0,0, 1,3,k,'hA0+k,0, 1,  0,0,0,0, 1,0);
        add(0,0, 0,0,0,0,0, 1,  1,3,0,32'hA3A2A1A0, 1,0);
        add(0,0, 0,0,0,0,0, 1,  0,0,0,0, 0,0);
        // out-of-order interleave, entries 1 and 2
        add(1,1, 0,0,0,0,0, 1,  0,0,0,0, 1,0);
        add(1,2, 0,0,0,0,0, 1,  0,0,0,0, 2,0);
        add(0,0, 1,2,3,'h23,0, 1,  0,0,0,0, 2,0);
        add(0,0, 1,1,1,'h11,0, 1,  0,0,0,0, 2,0);
        add(0,0, 1,2,0,'h20,0, 1,  0,0,0,0, 2,0);
        add(0,0, 1,1,0,'h10,0, 1,  0,0,0,0, 2,0);
        add(0,0, 1,2,2,'h22,0, 1,  0,0,0,0, 2,0);
        add(0,0, 1,1,3,'h13,0, 1,  0,0,0,0, 2,0);
        add(0,0, 1,2,1,'h21,0, 1,  0,0,0,0, 2,0);
        add(0,0, 1,1,2,'h12,0, 1,  1,2,0,32'h23222120, 2,0);
        add(0,0, 0,0,0,0,0, 1,  1,1,0,32'h13121110, 1,0);
        add(0,0, 0,0,0,0,0, 1,  0,0,0,0, 0,0);
        // backpressure and round-robin over entries 0, 5, 6
        add(1,0, 0,0,0,0,0, 0,  0,0,0,0, 1,0);
        add(1,5, 0,0,0,0,0, 0,  0,0,0,0, 2,0);
        add(1,6, 0,0,0,0,0, 0,  0,0,0,0, 3,0);
        for (int k = 0; k < 4; k++) add(0,0, 1,0,k,k,0, 0,  0,0,0,0, 3,0);
        for (int k = 0; k < 4; k++) add(0,0, 1,5,k,'h50+k,0, 0,  1,0,0,32'h03020100, 3,0);
        for (int k = 0; k < 4; k++) add(0,0, 1,6,k,'h60+k,0, 0,  1,0,0,32'h03020100, 3,0);
        for (int k = 0; k < 5; k++) add(0,0, 0,0,0,0,0, 0,  1,0,0,32'h03020100, 3,0);
        add(0,0, 0,0,0,0,0, 1,  1,5,0,32'h53525150, 2,0);
        add(0,0, 0,0,0,0,0, 1,  1,6,0,32'h63626160, 1,0);
        add(0,0, 0,0,0,0,0, 1,  0,0,0,0, 0,0);
        // error propagation: entry 4 beat 2 flagged, entry 5 clean
        add(1,4, 0,0,0,0,0, 1,  0,0,0,0, 1,0);
        add(1,5, 0,0,0,0,0, 1,  0,0,0,0, 2,0);
        for (int k = 0; k < 4; k++) add(0,0, 1,4,k,'h40+k,(k==2), 1,  0,0,0,0, 2,0);
        add(0,0, 1,5,0,'h58,0, 1,  1,4,1,32'h43424140, 2,0);
        add(0,0, 1,5,1,'h59,0, 1,  0,0,0,0, 1,0);
        add(0,0, 1,5,2,'h5A,0, 1,  0,0,0,0, 1,0);
        add(0,0, 1,5,3,'h5B,0, 1,  0,0,0,0, 1,0);
        add(0,0, 0,0,0,0,0, 1,  1,5,0,32'h5B5A5958, 1,0);
        add(0,0, 0,0,0,0,0, 1,  0,0,0,0, 0,0);
        // protocol violations around entry 7
        add(0,0, 1,7,0,'h77,0, 1,  0,0,0,0, 0,1);
        add(1,7, 0,0,0,0,0, 1,  0,0,0,0, 1,1);
        add(0,0, 1,7,1,'h71,0, 1,  0,0,0,0, 1,1);
        add(0,0, 1,7,1,'h7E,0, 1,  0,0,0,0, 1,1);
        add(1,7, 0,0,0,0,0, 1,  0,0,0,0, 1,1);
        add(0,0, 1,7,0,'h70,0, 1,  0,0,0,0, 1,1);
        add(0,0, 1,7,2,'h72,0, 1,  0,0,0,0, 1,1);
        add(0,0, 1,7,3,'h73,0, 0,  0,0,0,0, 1,1);
        add(0,0, 1,7,0,'hEE,0, 0,  1,7,0,32'h73727E70, 1,1);
        add(0,0, 0,0,0,0,0, 0,  1,7,0,32'h73727E70, 1,1);
        add(0,0, 0,0,0,0,0, 1,  0,0,0,0, 0,1);
        sec6 = tbl.size();
        // after mid-collect reset: alloc+beat together, then retire+realloc together
        add(1,2, 1,2,1,'hB1,0, 0,  0,0,0,0, 1,0);
        add(0,0, 1,2,0,'hB0,0, 0,  0,0,0,0, 1,0);
        add(0,0, 1,2,3,'hB3,0, 0,  0,0,0,0, 1,0);
        add(0,0, 1,2,2,'hB2,0, 0,  0,0,0,0, 1,0);
        add(0,0, 0,0,0,0,0, 0,  1,2,0,32'hB3B2B1B0, 1,0);
        add(1,2, 0,0,0,0,0, 1,  0,0,0,0, 1,0);
        for (int k = 0; k < 4; k++) add(0,0, 1,2,k,'hC0+k,0, 1,  0,0,0,0, 1,0);
        add(0,0, 0,0,0,0,0, 1,  1,2,0,32'hC3C2C1C0, 1,0);
        add(0,0, 0,0,0,0,0, 1,  0,0,0,0, 0,0);

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #12;
        chk_reset_vals("por");
        #5 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post-reset rxdat_rdy", BW'(rxdat_rdy), BW'(1));

        run_rows(0, sec6);

        // partial collect on entry 2, then asynchronous reset mid-cycle
        drive(1, 2, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(0, 0, 1, 2, 0, 8'hD0, 0, 0);
        @(posedge clk); #1;
        drive(0, 0, 1, 2, 1, 8'hD1, 1, 0);
        @(posedge clk); #1;
        chk("mid pending_cnt", BW'(pending_cnt), BW'(1));
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("mid-rst");
        @(posedge clk); #1;
        chk_reset_vals("mid-rst held");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("re-reset rxdat_rdy", BW'(rxdat_rdy), BW'(1));

        run_rows(sec6, tbl.size());

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
